// File: rtl/acc_arb_pkg.sv
// Shared types and widths for the accumulator register-file access arbiter.
package acc_arb_pkg;

  localparam int DW         = 8;
  localparam int AW         = 2;
  localparam int ACC_ADDR_W = 13;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_ADD   = 2'b10,
    OP_SUB   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ACCESS = 2'b01,
    S_WB     = 2'b10,
    S_RESP   = 2'b11
  } state_e;

endpackage

// File: rtl/acc_access_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the first asserted request at or above
// ptr_i, wrapping around. The pointer register itself belongs to the parent.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  input  logic            en_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [PW-1:0]   gnt_idx_o
);

  logic [PW-1:0] cand;
  logic          found;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    cand      = '0;
    found     = 1'b0;
    for (int off = 0; off < NREQ; off++) begin
      cand = PW'((int'(ptr_i) + off) % NREQ);
      if (en_i && !found && req_i[cand]) begin
        found        = 1'b1;
        gnt_o[cand]  = 1'b1;
        gnt_idx_o    = cand;
      end
    end
  end

endmodule

// File: rtl/acc_access_arbiter.sv
// Shares the 4x8 accumulator register file between NREQ requesters with
// READ/WRITE/ADD/SUB operations. Define ACC_ARB_SAT_EN for saturating ADD/SUB.
module acc_access_arbiter
  import acc_arb_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [2*NREQ-1:0]     req_op,
  input  logic [AW*NREQ-1:0]    req_idx,
  input  logic [DW*NREQ-1:0]    req_wdata,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [DW-1:0]         rsp_data,
  output logic                  rsp_flag,
  output logic [ACC_ADDR_W-1:0] acc_addr,
  output logic [DW-1:0]         acc_wdata,
  output logic                  acc_we,
  input  logic [DW-1:0]         acc_rdata,
  output logic                  busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e                  state_q;
  op_e                     op_q;
  logic [DW-1:0]           wdata_q;
  logic [PW-1:0]           id_q;
  logic [PW-1:0]           ptr_q;
  logic                    flag_q;
  logic [ACC_ADDR_W-1:0]   acc_addr_q;
  logic [DW-1:0]           acc_wdata_q;
  logic                    acc_we_q;
  logic [NREQ-1:0]         rsp_valid_q;
  logic [DW-1:0]           rsp_data_q;
  logic                    rsp_flag_q;

  logic [NREQ-1:0]         gnt;
  logic [PW-1:0]           gnt_idx;
  op_e                     sel_op;
  logic [AW-1:0]           sel_idx;
  logic [DW-1:0]           sel_wdata;
  logic [DW:0]             wide_d;
  logic [DW-1:0]           res_d;
  logic                    flag_d;

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr (
    .req_i     (req_valid),
    .ptr_i     (ptr_q),
    .en_i      (state_q == S_IDLE),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  assign req_ready = gnt;
  assign sel_op    = op_e'(req_op[int'(gnt_idx)*2 +: 2]);
  assign sel_idx   = req_idx[int'(gnt_idx)*AW +: AW];
  assign sel_wdata = req_wdata[int'(gnt_idx)*DW +: DW];

  // One extra bit on the add/subtract carries the carry-out or borrow.
  always_comb begin
    wide_d = (op_q == OP_SUB) ? ({1'b0, acc_rdata} - {1'b0, wdata_q})
                              : ({1'b0, acc_rdata} + {1'b0, wdata_q});
    flag_d = wide_d[DW];
    res_d  = wide_d[DW-1:0];
`ifdef ACC_ARB_SAT_EN
    if (flag_d) res_d = (op_q == OP_SUB) ? '0 : '1;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= OP_READ;
      wdata_q     <= '0;
      id_q        <= '0;
      ptr_q       <= '0;
      flag_q      <= 1'b0;
      acc_addr_q  <= '0;
      acc_wdata_q <= '0;
      acc_we_q    <= 1'b0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_flag_q  <= 1'b0;
    end else begin
      rsp_valid_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (|gnt) begin
            op_q        <= sel_op;
            wdata_q     <= sel_wdata;
            id_q        <= gnt_idx;
            ptr_q       <= (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
            acc_addr_q  <= ACC_ADDR_W'(sel_idx);
            acc_we_q    <= (sel_op == OP_WRITE);
            acc_wdata_q <= (sel_op == OP_WRITE) ? sel_wdata : '0;
            state_q     <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (op_q == OP_ADD || op_q == OP_SUB) begin
            acc_we_q    <= 1'b1;
            acc_wdata_q <= res_d;
            flag_q      <= flag_d;
            state_q     <= S_WB;
          end else begin
            acc_we_q    <= 1'b0;
            acc_addr_q  <= '0;
            acc_wdata_q <= '0;
            rsp_valid_q <= NREQ'(1) << id_q;
            rsp_data_q  <= (op_q == OP_WRITE) ? wdata_q : acc_rdata;
            rsp_flag_q  <= 1'b0;
            state_q     <= S_RESP;
          end
        end
        // acc_wdata_q still holds the result being written back this cycle.
        S_WB: begin
          acc_we_q    <= 1'b0;
          acc_addr_q  <= '0;
          acc_wdata_q <= '0;
          rsp_valid_q <= NREQ'(1) << id_q;
          rsp_data_q  <= acc_wdata_q;
          rsp_flag_q  <= flag_q;
          state_q     <= S_RESP;
        end
        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign acc_addr  = acc_addr_q;
  assign acc_wdata = acc_wdata_q;
  assign acc_we    = acc_we_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_flag  = rsp_flag_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_acc_access_arbiter.sv
// Bench for acc_access_arbiter: models the register file, predicts results
// from plain integer arithmetic and checks every phase of each operation.
module tb_acc_access_arbiter;

  localparam logic [1:0] OP_RD  = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  reqValid;
  logic [1:0]  reqReady;
  logic [3:0]  reqOp;
  logic [3:0]  reqIdx;
  logic [15:0] reqWdata;
  logic [1:0]  rspValid;
  logic [7:0]  rspData;
  logic        rspFlag;
  logic [12:0] accAddr;
  logic [7:0]  accWdata;
  logic        accWe;
  logic [7:0]  accRdata;
  logic        busy;

  logic [7:0]  rf [4];
  logic [7:0]  modelRegs [4];
  int          weCount = 0;
  int          checks = 0;
  int          passes = 0;

  acc_access_arbiter #(.NREQ(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (reqValid),
    .req_ready (reqReady),
    .req_op    (reqOp),
    .req_idx   (reqIdx),
    .req_wdata (reqWdata),
    .rsp_valid (rspValid),
    .rsp_data  (rspData),
    .rsp_flag  (rspFlag),
    .acc_addr  (accAddr),
    .acc_wdata (accWdata),
    .acc_we    (accWe),
    .acc_rdata (accRdata),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Register file: combinational read, synchronous write, never reset.
  assign accRdata = rf[accAddr[1:0]];
  always @(posedge clk) begin
    if (accWe) begin
      rf[accAddr[1:0]] <= accWdata;
      weCount <= weCount + 1;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected result per operation, straight from the arithmetic definition.
  function automatic void predict(input logic [1:0] op, input logic [1:0] idx,
                                  input logic [7:0] wd, output logic [7:0] res,
                                  output logic flag);
    int full;
    flag = 1'b0;
    case (op)
      OP_RD: res = modelRegs[idx];
      OP_WR: res = wd;
      default: begin
        full = (op == OP_ADD) ? int'(modelRegs[idx]) + int'(wd)
                              : int'(modelRegs[idx]) - int'(wd);
        flag = (full > 255) || (full < 0);
        res  = 8'(full & 255);
`ifdef ACC_ARB_SAT_EN
        if (flag) res = (op == OP_ADD) ? 8'hFF : 8'h00;
`endif
      end
    endcase
    if (op != OP_RD) modelRegs[idx] = res;
  endfunction

  task automatic applyStimulus(input int r, input logic [1:0] op, input logic [1:0] idx,
                               input logic [7:0] wd);
    logic [7:0] expRes;
    logic       expFlag;
    int         waited;
    int         weBefore;
    logic [1:0] expHot;
    expHot = 2'(1 << r);
    predict(op, idx, wd, expRes, expFlag);
    @(posedge clk); #1;
    reqValid = 2'b00;
    reqValid[r] = 1'b1;
    reqOp[r*2 +: 2] = op;
    reqIdx[r*2 +: 2] = idx;
    reqWdata[r*8 +: 8] = wd;
    waited = 0;
    @(negedge clk);
    while (reqReady[r] !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("grant_onehot", 32'(reqReady), 32'(expHot));
    checkOutput("grant_latency", waited, 0);
    weBefore = weCount;
    @(posedge clk); #1;
    reqValid = 2'b00;
    reqOp    = 4'($urandom);
    reqIdx   = 4'($urandom);
    reqWdata = 16'($urandom);
    @(negedge clk);
    checkOutput("access_addr", 32'(accAddr), 32'(idx));
    checkOutput("access_we", 32'(accWe), 32'(op == OP_WR));
    checkOutput("access_ready", 32'(reqReady), 0);
    checkOutput("access_busy", 32'(busy), 1);
    if (op == OP_WR) checkOutput("access_wdata", 32'(accWdata), 32'(wd));
    if (op == OP_ADD || op == OP_SUB) begin
      @(negedge clk);
      checkOutput("wb_we", 32'(accWe), 1);
      checkOutput("wb_addr", 32'(accAddr), 32'(idx));
      checkOutput("wb_wdata", 32'(accWdata), 32'(expRes));
      checkOutput("wb_rsp_quiet", 32'(rspValid), 0);
    end
    @(negedge clk);
    checkOutput("rsp_valid", 32'(rspValid), 32'(expHot));
    checkOutput("rsp_data", 32'(rspData), 32'(expRes));
    checkOutput("rsp_flag", 32'(rspFlag), 32'(expFlag));
    checkOutput("rsp_we_low", 32'(accWe), 0);
    @(negedge clk);
    checkOutput("post_rsp_valid", 32'(rspValid), 0);
    checkOutput("post_busy", 32'(busy), 0);
    checkOutput("post_rsp_hold", 32'(rspData), 32'(expRes));
    checkOutput("post_addr", 32'(accAddr), 0);
    checkOutput("write_count", weCount - weBefore, (op != OP_RD) ? 1 : 0);
    checkOutput("regfile", 32'(rf[idx]), 32'(modelRegs[idx]));
  endtask

  initial begin
    logic [1:0] rOp;
    logic [1:0] rIdx;
    logic [7:0] rWd;
    int         waited;
    int         weBefore;
    int         winner;
    logic [1:0] arbIdx [2];

    rst = 1'b1;
    reqValid = '0; reqOp = '0; reqIdx = '0; reqWdata = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_we", 32'(accWe), 0);
    checkOutput("reset_rsp_valid", 32'(rspValid), 0);
    checkOutput("reset_rsp_data", 32'(rspData), 0);
    checkOutput("reset_rsp_flag", 32'(rspFlag), 0);
    checkOutput("reset_busy", 32'(busy), 0);
    checkOutput("reset_addr", 32'(accAddr), 0);
    rst = 1'b0;

    $display("[TB] write/read, add and sub boundary cases");
    applyStimulus(0, OP_WR, 2'd1, 8'h5A);
    applyStimulus(0, OP_RD, 2'd1, 8'h00);
    applyStimulus(1, OP_WR, 2'd2, 8'hF0);
    applyStimulus(0, OP_ADD, 2'd2, 8'h20);
    applyStimulus(0, OP_WR, 2'd3, 8'h05);
    applyStimulus(1, OP_SUB, 2'd3, 8'h07);
    applyStimulus(1, OP_WR, 2'd0, 8'h33);

    $display("[TB] randomized operations");
    for (int i = 0; i < 24; i++) begin
      rOp  = 2'($urandom_range(0, 3));
      rIdx = 2'($urandom_range(0, 3));
      rWd  = 8'($urandom);
      applyStimulus(int'($urandom_range(0, 1)), rOp, rIdx, rWd);
    end

    $display("[TB] reset during write-back");
    applyStimulus(0, OP_WR, 2'd0, 8'h10);
    weBefore = weCount;
    @(posedge clk); #1;
    reqValid = 2'b01; reqOp[1:0] = OP_ADD; reqIdx[1:0] = 2'd0; reqWdata[7:0] = 8'h01;
    @(negedge clk);
    checkOutput("abort_grant", 32'(reqReady), 1);
    @(posedge clk); #1;
    reqValid = 2'b00;
    @(posedge clk); #1;
    checkOutput("abort_in_wb", 32'(accWe), 1);
    rst = 1'b1;
    #1;
    checkOutput("abort_we", 32'(accWe), 0);
    checkOutput("abort_busy", 32'(busy), 0);
    repeat (2) begin
      @(negedge clk);
      checkOutput("abort_rsp", 32'(rspValid), 0);
    end
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_rsp_after", 32'(rspValid), 0);
    checkOutput("abort_no_write", weCount - weBefore, 0);
    applyStimulus(0, OP_RD, 2'd0, 8'h00);

    $display("[TB] round-robin with both requesters held");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    arbIdx[0] = 2'd1;
    arbIdx[1] = 2'd2;
    @(posedge clk); #1;
    reqValid = 2'b11; reqOp = {OP_RD, OP_RD}; reqIdx = {arbIdx[1], arbIdx[0]};
    for (int g = 0; g < 4; g++) begin
      winner = g % 2;
      waited = 0;
      @(negedge clk);
      while (reqReady === 2'b00 && waited < 10) begin
        @(negedge clk);
        waited++;
      end
      checkOutput("arb_grant", 32'(reqReady), 32'(1 << winner));
      checkOutput("arb_latency", waited, 0);
      @(negedge clk);
      checkOutput("arb_ready_access", 32'(reqReady), 0);
      @(negedge clk);
      checkOutput("arb_ready_resp", 32'(reqReady), 0);
      checkOutput("arb_rsp_valid", 32'(rspValid), 32'(1 << winner));
      checkOutput("arb_rsp_data", 32'(rspData), 32'(modelRegs[arbIdx[winner]]));
    end
    @(posedge clk); #1;
    reqValid = 2'b00;

    $display("[TB] idle hold");
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checkOutput("idle_we", 32'(accWe), 0);
      checkOutput("idle_addr", 32'(accAddr), 0);
      checkOutput("idle_busy", 32'(busy), 0);
    end
    applyStimulus(1, OP_RD, 2'd3, 8'h00);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
